// File: rtl/cellrv32_package.sv
// Shared FPU constants: fclass bit indices, exception flag indices and
// rounding-mode encodings used by the float-to-int conversion sequencer.
package cellrv32_package;

  // fclass one-hot bit positions
  localparam int unsigned fp_class_neg_inf_c    = 0;
  localparam int unsigned fp_class_neg_norm_c   = 1;
  localparam int unsigned fp_class_neg_denorm_c = 2;
  localparam int unsigned fp_class_neg_zero_c   = 3;
  localparam int unsigned fp_class_pos_zero_c   = 4;
  localparam int unsigned fp_class_pos_denorm_c = 5;
  localparam int unsigned fp_class_pos_norm_c   = 6;
  localparam int unsigned fp_class_pos_inf_c    = 7;
  localparam int unsigned fp_class_snan_c       = 8;
  localparam int unsigned fp_class_qnan_c       = 9;
  localparam int unsigned fp_class_width_c      = 10;

  // accrued exception flag positions (fflags)
  localparam int unsigned fp_exc_nx_c    = 0;
  localparam int unsigned fp_exc_uf_c    = 1;
  localparam int unsigned fp_exc_of_c    = 2;
  localparam int unsigned fp_exc_dz_c    = 3;
  localparam int unsigned fp_exc_nv_c    = 4;
  localparam int unsigned fp_exc_width_c = 5;

  // rounding modes
  localparam logic [2:0] rm_rne_c = 3'b000;
  localparam logic [2:0] rm_rtz_c = 3'b001;
  localparam logic [2:0] rm_rdn_c = 3'b010;
  localparam logic [2:0] rm_rup_c = 3'b011;
  localparam logic [2:0] rm_rmm_c = 3'b100;
  localparam logic [2:0] rm_dyn_c = 3'b111;

  typedef logic [fp_class_width_c-1:0] fp_class_t;
  typedef logic [fp_exc_width_c-1:0]   fp_flags_t;

endpackage

// File: rtl/cellrv32_cpu_cp_fpu32_classify.sv
// Combinational single-precision classifier producing the one-hot fclass code.
// Ports: operand (IEEE-754 single), fclass (one-hot class, 10 bits).
module cellrv32_cpu_cp_fpu32_classify
  import cellrv32_package::*;
(
  input  logic [31:0] operand,
  output fp_class_t   fclass
);

  logic       sign;
  logic       exp_max;
  logic       exp_zero;
  logic       mant_zero;

  assign sign      = operand[31];
  assign exp_max   = &operand[30:23];
  assign exp_zero  = ~|operand[30:23];
  assign mant_zero = ~|operand[22:0];

  // Exactly one class bit is set for every input pattern
  always_comb begin
    fclass = '0;
    if (exp_max && !mant_zero) begin
      if (operand[22]) fclass[fp_class_qnan_c] = 1'b1;
      else             fclass[fp_class_snan_c] = 1'b1;
    end else if (exp_max) begin
      if (sign) fclass[fp_class_neg_inf_c] = 1'b1;
      else      fclass[fp_class_pos_inf_c] = 1'b1;
    end else if (exp_zero && mant_zero) begin
      if (sign) fclass[fp_class_neg_zero_c] = 1'b1;
      else      fclass[fp_class_pos_zero_c] = 1'b1;
    end else if (exp_zero) begin
      if (sign) fclass[fp_class_neg_denorm_c] = 1'b1;
      else      fclass[fp_class_pos_denorm_c] = 1'b1;
    end else begin
      if (sign) fclass[fp_class_neg_norm_c] = 1'b1;
      else      fclass[fp_class_pos_norm_c] = 1'b1;
    end
  end

endmodule

// File: rtl/cellrv32_cpu_cp_fpu32_cvt_seq.sv
// Float-to-integer conversion sequencer: captures the operand, resolves the
// rounding mode, classifies the operand, launches the external converter and
// returns its result while accruing the fflags CSR.
// Ports: clk_i/rst_i (async active-high); start_i, rs1_i, rm_i, frm_i, funct_i,
// abort_i, fflags_we_i/fflags_wdata_i (CPU request side); cvt_* (converter
// handshake); busy_o, valid_o, illegal_o, result_o, fflags_o (CPU response).
module cellrv32_cpu_cp_fpu32_cvt_seq
  import cellrv32_package::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [31:0]     rs1_i,
  input  logic [2:0]      rm_i,
  input  logic [2:0]      frm_i,
  input  logic            funct_i,
  input  logic            abort_i,
  input  logic            fflags_we_i,
  input  fp_flags_t       fflags_wdata_i,
  output logic            cvt_start_o,
  output logic [2:0]      cvt_rmode_o,
  output logic            cvt_funct_o,
  output logic            cvt_sign_o,
  output logic [7:0]      cvt_exponent_o,
  output logic [22:0]     cvt_mantissa_o,
  output fp_class_t       cvt_class_o,
  input  logic [XLEN-1:0] cvt_result_i,
  input  fp_flags_t       cvt_flags_i,
  input  logic            cvt_done_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] result_o,
  output fp_flags_t       fflags_o
);

  localparam int unsigned CntW = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_LAUNCH, S_WAIT, S_DRAIN, S_DONE
  } state_t;

  state_t          state;
  logic [31:0]     rs1_q;
  logic            funct_q;
  logic [2:0]      rm_q;
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  fp_class_t       class_c;
  logic            flag_acc_c;

  cellrv32_cpu_cp_fpu32_classify u_classify (
    .operand (rs1_q),
    .fclass  (class_c)
  );

  // Converter flags accrue only for a live, non-aborted completion
  assign flag_acc_c = (state == S_WAIT) && cvt_done_i && !abort_i;

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      rs1_q          <= '0;
      funct_q        <= 1'b0;
      rm_q           <= '0;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      cvt_start_o    <= 1'b0;
      cvt_rmode_o    <= '0;
      cvt_funct_o    <= 1'b0;
      cvt_sign_o     <= 1'b0;
      cvt_exponent_o <= '0;
      cvt_mantissa_o <= '0;
      cvt_class_o    <= '0;
      busy_o         <= 1'b0;
      valid_o        <= 1'b0;
      illegal_o      <= 1'b0;
      result_o       <= '0;
      fflags_o       <= '0;
    end else begin
      cvt_start_o <= 1'b0;
      valid_o     <= 1'b0;
      // CSR write and converter accrual may coincide; both contribute
      fflags_o    <= (fflags_we_i ? fflags_wdata_i : fflags_o) |
                     (flag_acc_c ? cvt_flags_i : fp_flags_t'(0));
      case (state)
        S_IDLE: begin
          if (start_i) begin
            rs1_q   <= rs1_i;
            funct_q <= funct_i;
            rm_q    <= (rm_i == rm_dyn_c) ? frm_i : rm_i;
            busy_o  <= 1'b1;
            state   <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else if (rm_q > rm_rmm_c) begin
            valid_o   <= 1'b1;
            illegal_o <= 1'b1;
            result_o  <= '0;
            state     <= S_DONE;
          end else begin
            cvt_sign_o     <= rs1_q[31];
            cvt_exponent_o <= rs1_q[30:23];
            cvt_mantissa_o <= rs1_q[22:0];
            cvt_class_o    <= class_c;
            cvt_rmode_o    <= rm_q;
            cvt_funct_o    <= funct_q;
            cvt_start_o    <= 1'b1;
            state          <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (abort_i) begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            // A completion in the abort cycle already closes the operation
            if (cvt_done_i) begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end else begin
              state  <= S_DRAIN;
            end
          end else if (cvt_done_i) begin
            result_o  <= cvt_result_i;
            illegal_o <= 1'b0;
            valid_o   <= 1'b1;
            state     <= S_DONE;
          end else if (&cnt_q) begin
            timeout_q <= 1'b1;
            state     <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        S_DRAIN: begin
          // Converter output is discarded; a timed-out op still reports back
          if (cvt_done_i) begin
            if (timeout_q) begin
              valid_o   <= 1'b1;
              illegal_o <= 1'b1;
              result_o  <= '0;
              state     <= S_DONE;
            end else begin
              busy_o <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
